cordic_rotator: RTL and testbench
=================================

Name: cordic_rotator

Overview:
- Iterative rotation-mode CORDIC engine computing cosine and sine of an angle by rotating an input vector.
- Angles are in radians; all data are signed Q2.30 fixed-point (0x40000000 = 1.0).
- Sits in the trigonometric-calculator datapath.
- Optionally followed by a decimal scaler that yields 4-digit values for display (1.0 -> 10000).

Parameters:
- ITER, 30, number of micro-rotations (1..30).
- W, 32, data/angle width (Q2.30); fixed at 32 in this revision.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy=0
- angle  in  32  signed Q2.30 radians
- x_in  in  32  signed Q2.30 initial X (nominally 0x40000000)
- y_in  in  32  signed Q2.30 initial Y (nominally 0)
- busy  out  1  high while an operation is in flight
- valid  out  1  one-cycle pulse when results update
- cos_out  out  32  signed Q2.30 rotated X (cosine for unit input)
- sin_out  out  32  signed Q2.30 rotated Y (sine for unit input)

Behaviour:
- Reset: busy=0, valid=0, cos_out=0, sin_out=0, iteration counter=0, internal x/y/z=0.
- Reset mid-operation aborts the operation; no valid is produced.
- States: IDLE, ROTATE, SCALE.
- IDLE: on start=1, load x=x_in, y=y_in, z=clamped angle, i=0, busy=1; go to ROTATE.
- Angle clamp: angle > +pi/2 (0x6487ED51) clamps to 0x6487ED51; angle < -pi/2 clamps to 0x9B7812AF.
- ROTATE, one micro-rotation per cycle:
  - d = +1 if z >= 0, else -1.
  - x' = x - d*(y >>> i); y' = y + d*(x >>> i); z' = z - d*ATAN[i].
  - >>> is an arithmetic shift; all adds wrap at 32 bits.
  - After i = ITER-1, go to SCALE.
- SCALE:
  - cos_out = (x * KINV) >>> 30; sin_out = (y * KINV) >>> 30.
  - Full 64-bit signed product, truncated to 32 bits.
  - Pulse valid=1 for one cycle, busy=0, return to IDLE.
- Latency: start accepted at cycle 0; valid at cycle ITER+1; next start accepted on the cycle after valid.
- start while busy=1 is ignored; outputs are unchanged during an operation.
- Outputs hold between operations.
- Accuracy with ITER=30, unit input: |error| <= 16 LSB per output.

Optional Feature:
- Macro: CORDIC_DEC4_OUT_EN.
- When defined, adds two ports:
  - cos_dec  out  16
  - sin_dec  out  16
- Each is a signed decimal approximation, registered in the same cycle valid pulses:
  - m = bits [30:17] of |value| (14 bits, 13 fractional).
  - dec = floor(m*10000 >> 13), negated if value < 0.
  - Range -10000..+10000 (0x40000000 -> 10000).
  - Reset value 0.
- When undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package cordic_pkg holds:
  - Q2.30 typedef.
  - ATAN table, atan(2^-i) rounded to Q2.30, i = 0..29. ATAN[0] = 0x3243F6A9, ATAN[1] = 0x1DAC6705.
  - KINV = 0x26DD3B6A (0.6072529350).
  - HALF_PI = 0x6487ED51.
  - State enum.
- One sub-module, fixed_to_dec4: combinational Q2.30-to-4-digit scaler, instantiated only under CORDIC_DEC4_OUT_EN.

Test Plan:
- angle=0, x_in=0x40000000, y_in=0, start -> valid at cycle 31; cos_out 0x40000000 ±16; sin_out 0 ±16; cos_dec 10000 (±1).
- Sweep 0 to 85 degrees in steps of 0x0595C612 (5 degrees) -> 5-degree cos_dec 9961 ±1; 60-degree (0x430548E2) cos_out 0x20000000 ±16, cos_dec 5000 ±1.
- angle=0xDE7D5B8F (-30 degrees) -> cos_out 0x376CF5D1 ±16; sin_out 0xE0000000 ±16; sin_dec -5000 ±1.
- angle=0x7FFFFFFF (out of range) -> clamped to pi/2; cos_out 0 ±16; sin_out 0x40000000 ±16.
- start pulsed again while busy, with a different angle -> ignored; single valid pulse; results match the first angle only.
- reset asserted mid-ROTATE -> next cycle busy=0, valid=0, outputs 0; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/cordic_pkg.sv
// cordic_pkg: Q2.30 types, arctangent table, gain constant and FSM states for cordic_rotator
package cordic_pkg;
  typedef logic signed [31:0] q2_30_t;
  typedef enum logic [1:0] {IDLE, ROTATE, SCALE} state_t;
  localparam q2_30_t HALF_PI = 32'sh6487ED51;
  localparam q2_30_t KINV = 32'sh26DD3B6A;
  localparam q2_30_t ATAN [30] = '{
    32'sh3243F6A9, 32'sh1DAC6705, 32'sh0FADBAFD, 32'sh07F56EA7, 32'sh03FEAB77,
    32'sh01FFD55C, 32'sh00FFFAAB, 32'sh007FFF55, 32'sh003FFFEB, 32'sh001FFFFD,
    32'sh00100000, 32'sh00080000, 32'sh00040000, 32'sh00020000, 32'sh00010000,
    32'sh00008000, 32'sh00004000, 32'sh00002000, 32'sh00001000, 32'sh00000800,
    32'sh00000400, 32'sh00000200, 32'sh00000100, 32'sh00000080, 32'sh00000040,
    32'sh00000020, 32'sh00000010, 32'sh00000008, 32'sh00000004, 32'sh00000002
  };
  function automatic q2_30_t clamp_angle(input q2_30_t a);
    return a > HALF_PI ? HALF_PI : a < -HALF_PI ? -HALF_PI : a;
  endfunction
endpackage

// File: rtl/cordic_rotator_fixed_to_dec4.sv
// fixed_to_dec4: combinational Q2.30 to signed 4-digit decimal scaler (1.0 -> 10000)
module fixed_to_dec4 (
  input  logic [31:0] value,
  output logic [15:0] dec
);
  logic [13:0] m;
  logic [27:0] prod;
  logic [14:0] q;
  always_comb begin
    m = 14'((value[31] ? -value : value) >> 17);
    prod = 28'(m) * 28'd10000;
    q = 15'(prod >> 13);
    dec = value[31] ? -{1'b0, q} : {1'b0, q};
  end
endmodule

// File: rtl/cordic_rotator.sv
// cordic_rotator: iterative rotation-mode CORDIC (cos/sin); CORDIC_DEC4_OUT_EN adds decimal outputs
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int ITER = 30,
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] angle,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] cos_out,
`ifdef CORDIC_DEC4_OUT_EN
  output logic [W-1:0] sin_out,
  output logic [15:0]  cos_dec,
  output logic [15:0]  sin_dec
`else
  output logic [W-1:0] sin_out
`endif
);
  localparam logic [4:0] LAST = 5'(ITER - 1);
  state_t state, state_n;
  q2_30_t x, y, z, x_rot, y_rot, z_rot, cos_n, sin_n;
  logic signed [63:0] px, py;
  logic [4:0] i;
  always_comb begin
    x_rot = z[31] ? x + (y >>> i) : x - (y >>> i);
    y_rot = z[31] ? y - (x >>> i) : y + (x >>> i);
    z_rot = z[31] ? z + ATAN[i] : z - ATAN[i];
    px = 64'(x) * 64'(KINV);
    py = 64'(y) * 64'(KINV);
    cos_n = 32'(px >>> 30);
    sin_n = 32'(py >>> 30);
    state_n = state == IDLE ? (start ? ROTATE : IDLE) :
              state == ROTATE ? (i == LAST ? SCALE : ROTATE) : IDLE;
  end
`ifdef CORDIC_DEC4_OUT_EN
  logic [15:0] cos_dec_n, sin_dec_n;
  fixed_to_dec4 u_cos_dec (.value(cos_n), .dec(cos_dec_n));
  fixed_to_dec4 u_sin_dec (.value(sin_n), .dec(sin_dec_n));
  always_ff @(posedge clk)
    if (reset) begin
      cos_dec <= '0;
      sin_dec <= '0;
    end else if (state == SCALE) begin
      cos_dec <= cos_dec_n;
      sin_dec <= sin_dec_n;
    end
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      busy <= 1'b0;
      valid <= 1'b0;
      cos_out <= '0;
      sin_out <= '0;
      i <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
    end else begin
      valid <= 1'b0;
      if (state == IDLE && start) begin
        x <= x_in;
        y <= y_in;
        z <= clamp_angle(angle);
        i <= '0;
        busy <= 1'b1;
      end else if (state == ROTATE) begin
        x <= x_rot;
        y <= y_rot;
        z <= z_rot;
        i <= i + 5'd1;
      end else if (state == SCALE) begin
        cos_out <= cos_n;
        sin_out <= sin_n;
        valid <= 1'b1;
        busy <= 1'b0;
      end
    end
endmodule

// File: tb/tb_cordic_rotator.sv
// tb_cordic_rotator: directed self-checking bench for cordic_rotator
module tb_cordic_rotator;
  logic clk = 1'b0, reset, start;
  logic [31:0] angle, x_in, y_in, cos_out, sin_out;
  logic busy, valid;
`ifdef CORDIC_DEC4_OUT_EN
  logic [15:0] cos_dec, sin_dec;
`endif
  int compared = 0, mismatched = 0;
  always #5 clk = ~clk;
  cordic_rotator dut (
    .clk(clk), .reset(reset), .start(start), .angle(angle), .x_in(x_in), .y_in(y_in),
    .busy(busy), .valid(valid), .cos_out(cos_out),
`ifdef CORDIC_DEC4_OUT_EN
    .sin_out(sin_out), .cos_dec(cos_dec), .sin_dec(sin_dec)
`else
    .sin_out(sin_out)
`endif
  );
  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    compared++;
    if (got - exp > tol || exp - got > tol) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask
  task automatic run(input logic [31:0] a, output int cycles);
    @(negedge clk);
    angle = a;
    x_in = 32'h40000000;
    y_in = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    while (cycles < 100) begin
      @(posedge clk);
      #1 cycles++;
      if (valid) break;
    end
    if (cycles >= 100) check("timeout", cycles, 31, 0);
  endtask
  function automatic longint to_q30(input real r);
    real s = r * 1073741824.0;
    return longint'($rtoi(s >= 0.0 ? s + 0.5 : s - 0.5));
  endfunction
  initial begin
    int n, pulses, first;
    logic [31:0] cap_cos, cap_sin;
    real rad;
    reset = 1'b1;
    start = 1'b0;
    angle = '0;
    x_in = '0;
    y_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0, 0);
    check("rst_valid", valid, 0, 0);
    check("rst_cos", $signed(cos_out), 0, 0);
    check("rst_sin", $signed(sin_out), 0, 0);
    reset = 1'b0;
    run(32'h0, n);
    check("latency", n, 31, 0);
    check("cos0", $signed(cos_out), 32'sh40000000, 16);
    check("sin0", $signed(sin_out), 0, 16);
`ifdef CORDIC_DEC4_OUT_EN
    check("cos0_dec", $signed(cos_dec), 10000, 2);
`endif
    @(posedge clk);
    #1;
    check("valid_one_cycle", valid, 0, 0);
    check("idle_busy", busy, 0, 0);
    check("hold_cos0", $signed(cos_out), 32'sh40000000, 16);
    for (int k = 0; k < 18; k++) begin
      run(32'(k) * 32'h0595C612, n);
      rad = real'(k) * 5.0 * 3.14159265358979 / 180.0;
      check($sformatf("sweep_cos_%0d", k * 5), $signed(cos_out), to_q30($cos(rad)), 20);
      check($sformatf("sweep_sin_%0d", k * 5), $signed(sin_out), to_q30($sin(rad)), 20);
`ifdef CORDIC_DEC4_OUT_EN
      if (k == 1) check("cos5_dec", $signed(cos_dec), 9961, 2);
`endif
    end
    run(32'h430548E2, n);
    check("cos60", $signed(cos_out), 32'sh20000000, 16);
`ifdef CORDIC_DEC4_OUT_EN
    check("cos60_dec", $signed(cos_dec), 5000, 2);
`endif
    run(32'hDE7D5B8F, n);
    check("cos_m30", $signed(cos_out), 32'sh376CF5D1, 16);
    check("sin_m30", $signed(sin_out), -longint'(32'h20000000), 16);
`ifdef CORDIC_DEC4_OUT_EN
    check("sin_m30_dec", $signed(sin_dec), -5000, 2);
`endif
    run(32'h7FFFFFFF, n);
    check("clamp_cos", $signed(cos_out), 0, 16);
    check("clamp_sin", $signed(sin_out), 32'sh40000000, 16);
    run(32'h80000000, n);
    check("clamp_neg_sin", $signed(sin_out), -longint'(32'h40000000), 16);
    @(negedge clk);
    angle = 32'h2182A471;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    pulses = 0;
    first = 0;
    cap_cos = '0;
    cap_sin = '0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 5) begin
        angle = 32'h0;
        start = 1'b1;
      end
      if (c == 6) start = 1'b0;
      @(posedge clk);
      #1;
      if (valid) begin
        pulses++;
        if (first == 0) first = c;
        cap_cos = cos_out;
        cap_sin = sin_out;
      end
    end
    check("busy_pulses", pulses, 1, 0);
    check("busy_latency", first, 31, 0);
    check("busy_cos30", $signed(cap_cos), 32'sh376CF5D1, 16);
    check("busy_sin30", $signed(cap_sin), 32'sh20000000, 16);
    @(negedge clk);
    angle = 32'h2182A471;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0, 0);
    check("midrst_valid", valid, 0, 0);
    check("midrst_cos", $signed(cos_out), 0, 0);
    check("midrst_sin", $signed(sin_out), 0, 0);
`ifdef CORDIC_DEC4_OUT_EN
    check("midrst_cos_dec", $signed(cos_dec), 0, 0);
`endif
    reset = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 if (valid) pulses++;
    end
    check("midrst_no_valid", pulses, 0, 0);
    run(32'h430548E2, n);
    check("after_rst_latency", n, 31, 0);
    check("after_rst_cos60", $signed(cos_out), 32'sh20000000, 16);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
